// File: rtl/trg_stim_pkg.sv
// Shared types and constants for the trigger stimulus sequencer.
package trg_stim_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StHold,
        StSettle,
        StRun,
        StFinish
    } state_e;

    localparam logic [1:0] MODE_SINGLE   = 2'd0;
    localparam logic [1:0] MODE_PERIODIC = 2'd1;
    localparam logic [1:0] MODE_WALK     = 2'd2;
    localparam logic [1:0] MODE_RANDOM   = 2'd3;

    // x^16 + x^14 + x^13 + x^11 -> register bits 15, 13, 12, 10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/trg_stim_lfsr.sv
// 16-bit Fibonacci LFSR; shifts left and feeds the tap parity into bit 0.
module trg_stim_lfsr
    import trg_stim_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        step_i,
    output logic [15:0] value_o
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    // Next value: shift left, parity of tapped bits enters at the bottom.
    always_comb begin
        lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
    end

    // State register; only an explicit step advances the sequence.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lfsr_q <= SEED;
        end else if (step_i) begin
            lfsr_q <= lfsr_d;
        end
    end

    assign value_o = lfsr_q;

endmodule

// File: rtl/trg_stim_seq.sv
// Trigger stimulus sequencer: reset hold, settle gap, then trigger pulse slots.
module trg_stim_seq
    import trg_stim_pkg::*;
#(
    parameter int unsigned NCH      = 6,
    parameter int unsigned HOLD_CYC = 3000,
    parameter int unsigned GAP_CYC  = 150,
    parameter int unsigned CNT_W    = 16,
    parameter logic [15:0] SEED     = 16'hACE1
) (
    input  logic             CLK,
    input  logic             SYS_RST,
    input  logic             START,
    input  logic [1:0]       MODE,
    input  logic [CNT_W-1:0] PERIOD,
    input  logic [7:0]       NPULSE,
    input  logic [NCH-1:0]   CH_MASK,
    output logic             RST_OUT,
    output logic [NCH-1:0]   TRG,
    output logic             BUSY,
    output logic             DONE,
    output logic [7:0]       PULSE_CNT
);

    localparam int unsigned PTR_W = (NCH > 1) ? $clog2(NCH) : 1;
    // Counters load N-1 so that a phase lasts exactly N cycles.
    localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(GAP_CYC - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         pulse_cnt_q, pulse_cnt_d;
    logic [NCH-1:0]     trg_q, trg_d;
    logic               rst_out_q, rst_out_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [1:0]         mode_q;
    logic [CNT_W-1:0]   period_q;
    logic [7:0]         npulse_q;
    logic [NCH-1:0]     mask_q;
    logic               latch_en;

    logic [PTR_W-1:0]   walk_ptr_q, walk_nxt;
    logic [15:0]        lfsr_val;
    logic               fire;
    logic [NCH-1:0]     slot_trg;
    logic [7:0]         npulse_eff;
    logic [CNT_W-1:0]   period_ld;

    // Single mode always issues exactly one slot; PERIOD 0 behaves like 1.
    always_comb begin
        npulse_eff = (mode_q == MODE_SINGLE) ? 8'd1 : npulse_q;
        period_ld  = (period_q <= CNT_W'(1)) ? '0 : period_q - CNT_W'(1);
    end

    // Trigger pattern for the slot being issued.
    always_comb begin
        slot_trg = '0;
        unique case (mode_q)
            MODE_SINGLE, MODE_PERIODIC: slot_trg = mask_q;
            MODE_WALK:                  slot_trg = (NCH'(1) << walk_ptr_q) & mask_q;
            MODE_RANDOM:                slot_trg = lfsr_val[NCH-1:0] & mask_q;
            default:                    slot_trg = '0;
        endcase
    end

    // Next enabled channel above the walk pointer, wrapping; holds if mask is empty.
    always_comb begin
        int unsigned idx;
        logic        found;
        walk_nxt = walk_ptr_q;
        found    = 1'b0;
        for (int unsigned i = 1; i <= NCH; i++) begin
            idx = int'(walk_ptr_q) + i;
            if (idx >= NCH) begin
                idx = idx - NCH;
            end
            if (!found && mask_q[PTR_W'(idx)]) begin
                found    = 1'b1;
                walk_nxt = PTR_W'(idx);
            end
        end
    end

    // FSM next state plus next values of every registered output.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pulse_cnt_d = pulse_cnt_q;
        trg_d       = '0;
        rst_out_d   = rst_out_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        latch_en    = 1'b0;
        fire        = 1'b0;
        unique case (state_q)
            StIdle: begin
                rst_out_d = 1'b1;
                busy_d    = 1'b0;
                if (START) begin
                    state_d     = StHold;
                    cnt_d       = HOLD_LD;
                    pulse_cnt_d = '0;
                    latch_en    = 1'b1;
                    busy_d      = 1'b1;
                end
            end
            StHold: begin
                if (cnt_q == '0) begin
                    state_d   = StSettle;
                    cnt_d     = GAP_LD;
                    rst_out_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StSettle: begin
                if (cnt_q == '0) begin
                    if (npulse_eff == 8'd0) begin
                        state_d = StFinish;
                        done_d  = 1'b1;
                    end else begin
                        state_d = StRun;
                        fire    = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StRun: begin
                if (pulse_cnt_q == npulse_eff) begin
                    state_d = StFinish;
                    done_d  = 1'b1;
                end else if (cnt_q == '0) begin
                    fire = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StFinish: begin
                state_d   = StIdle;
                rst_out_d = 1'b1;
                busy_d    = 1'b0;
            end
            default: begin
                state_d   = StIdle;
                rst_out_d = 1'b1;
                busy_d    = 1'b0;
            end
        endcase
        // A slot is registered on the same edge that enters its cycle.
        if (fire) begin
            cnt_d       = period_ld;
            pulse_cnt_d = pulse_cnt_q + 8'd1;
            trg_d       = slot_trg;
        end
    end

    // FSM, counters and registered outputs.
    always_ff @(posedge CLK or posedge SYS_RST) begin
        if (SYS_RST) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            pulse_cnt_q <= '0;
            trg_q       <= '0;
            rst_out_q   <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pulse_cnt_q <= pulse_cnt_d;
            trg_q       <= trg_d;
            rst_out_q   <= rst_out_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Run parameters captured on an accepted START.
    always_ff @(posedge CLK or posedge SYS_RST) begin
        if (SYS_RST) begin
            mode_q   <= MODE_SINGLE;
            period_q <= '0;
            npulse_q <= '0;
            mask_q   <= '0;
        end else if (latch_en) begin
            mode_q   <= MODE;
            period_q <= PERIOD;
            npulse_q <= NPULSE;
            mask_q   <= CH_MASK;
        end
    end

    // Walk pointer survives across runs; only the system reset clears it.
    always_ff @(posedge CLK or posedge SYS_RST) begin
        if (SYS_RST) begin
            walk_ptr_q <= '0;
        end else if (fire && mode_q == MODE_WALK) begin
            walk_ptr_q <= walk_nxt;
        end
    end

    trg_stim_lfsr #(
        .SEED (SEED)
    ) u_lfsr (
        .clk_i   (CLK),
        .rst_i   (SYS_RST),
        .step_i  (fire && mode_q == MODE_RANDOM),
        .value_o (lfsr_val)
    );

    assign RST_OUT   = rst_out_q;
    assign TRG       = trg_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign PULSE_CNT = pulse_cnt_q;

endmodule

// File: doc/trg_stim_seq.md
# trg_stim_seq

Parametrised, synthesizable trigger-simulation stimulus sequencer for the DCFEB trigger path. It holds the downstream reset for a programmable hold, waits a settle gap after release, then issues one-cycle trigger pulses on up to NCH channels in one of four modes. It generalises the fixed reset-hold / wait stimulus used in the trigger simulation top so that on-chip self-test and bench runs share the same source.

## Interface
- NCH, 6, number of trigger channels
- HOLD_CYC, 3000, cycles RST_OUT is held high after START
- GAP_CYC, 150, settle cycles between reset release and first trigger
- CNT_W, 16, width of period and internal cycle counters
- SEED, 16'hACE1, nonzero LFSR seed
- CLK  in  1  system clock; single clock domain
- SYS_RST  in  1  asynchronous, active-high reset
- START  in  1  one-cycle start request, sampled only in IDLE
- MODE  in  2  0 single, 1 periodic, 2 walking, 3 random
- PERIOD  in  CNT_W  cycles between pulses; values 0 and 1 both mean 1
- NPULSE  in  8  number of pulse slots to issue
- CH_MASK  in  NCH  enabled channels
- RST_OUT  out  1  reset to the stimulated logic
- TRG  out  NCH  one-cycle trigger pulses
- BUSY  out  1  high from HOLD through FINISH
- DONE  out  1  one-cycle completion strobe
- PULSE_CNT  out  8  slots issued in the current run

## Operation
- Reset values: RST_OUT=1, TRG=0, BUSY=0, DONE=0, PULSE_CNT=0, FSM=IDLE, LFSR=SEED, walk pointer=0.
- States: IDLE, HOLD, SETTLE, RUN, FINISH.
- IDLE: RST_OUT=1. START latches MODE, PERIOD, NPULSE and CH_MASK, clears PULSE_CNT and goes to HOLD. START in any other state is ignored.
- HOLD: RST_OUT=1 for HOLD_CYC cycles, then SETTLE.
- SETTLE: RST_OUT=0 for GAP_CYC cycles, then RUN. If the latched NPULSE=0, go to FINISH instead.
- RUN: a pulse slot occurs on the first RUN cycle and then every PERIOD cycles. Each slot increments PULSE_CNT. After the slot where PULSE_CNT reaches NPULSE, go to FINISH.
  - Mode 0: exactly one slot, TRG=CH_MASK; NPULSE is ignored and treated as 1.
  - Mode 1: TRG=CH_MASK in every slot.
  - Mode 2: TRG is one-hot at the walk pointer. The pointer then advances to the next set bit of the mask, searching upward and wrapping modulo NCH. With CH_MASK=0, TRG stays 0.
  - Mode 3: TRG = LFSR[NCH-1:0] & CH_MASK. The LFSR (x^16+x^14+x^13+x^11) steps once per slot.
- Slots with an all-zero TRG still count.
- FINISH: DONE=1 for exactly one cycle, then IDLE. RST_OUT stays 0 in FINISH and returns to 1 on IDLE entry.
- LFSR and walk pointer persist across runs; only SYS_RST restores them.
- SYS_RST mid-run: all outputs return asynchronously to their reset values; any in-flight pulse is dropped.

## Timing
- START at cycle t:
  - HOLD covers t+1..t+HOLD_CYC with RST_OUT=1.
  - RST_OUT falls at t+HOLD_CYC+1.
  - First TRG at t+HOLD_CYC+GAP_CYC+1.
  - Slot k (0-based) at first+k*PERIOD.
  - DONE one cycle after the last slot; BUSY falls together with DONE.
- All outputs are registered. TRG is exactly one cycle wide, including when PERIOD=1 (back-to-back pulses).
- PULSE_CNT updates in the same cycle TRG is asserted.
- Period counter: CNT_W bits, no overflow inside RUN; the maximum PERIOD is 2^CNT_W-1.

## Structure
- Package trg_stim_pkg holds:
  - the state enum;
  - MODE constants (MODE_SINGLE, MODE_PERIODIC, MODE_WALK, MODE_RANDOM);
  - the LFSR tap mask.
- Sub-module trg_stim_lfsr: 16-bit Fibonacci LFSR with SEED parameter, step enable, async reset.
- The FSM, counters and walk-pointer logic stay in trg_stim_seq.

## Test plan
- HOLD_CYC=10, GAP_CYC=5, MODE=0, CH_MASK=6'h3F, START at t=0 -> RST_OUT high through t=10, low at t=11; TRG=6'h3F only at t=16; DONE at t=17; PULSE_CNT=1.
- MODE=1, PERIOD=4, NPULSE=3, CH_MASK=6'h05 -> TRG=6'h05 at first, first+4, first+8; DONE at first+9.
- MODE=2, PERIOD=1, NPULSE=4, CH_MASK=6'b100101 -> TRG=6'h01, 6'h04, 6'h20, 6'h01 on consecutive cycles.
- MODE=3, PERIOD=2, NPULSE=8, CH_MASK=6'h0F -> TRG equals the model LFSR from SEED ANDed with 4'hF; PULSE_CNT=8.
- Edge cases:
  - NPULSE=0 -> no TRG; DONE one cycle after SETTLE ends.
  - CH_MASK=0 in mode 1 -> TRG stays 0 while PULSE_CNT still counts.
  - START pulsed while BUSY -> ignored.
- SYS_RST asserted mid-RUN -> same cycle: RST_OUT=1, TRG=0, BUSY=0. After release: FSM in IDLE, and the next START replays the LFSR sequence from SEED.
